// File: rtl/xb_mem8_pkg.sv
// Shared constants, state encoding and pointer helper for the Xillybus 8-bit mem-stream responder.
// The optional end-of-file behaviour is selected with the XB_MEM8_EOF_EN macro in xb_mem8_responder.
package xb_mem8_pkg;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    SEEK   = 2'd2
  } state_e;

  // Pointer advance wraps naturally at DEPTH because the pointer is exactly AW bits.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return p + {{(AW-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/xb_mem8_regfile.sv
// DEPTH x DW flop register file: one host write and one fabric write (host wins on a collision),
// plus two registered read ports that return the value present before any same-edge write.
module xb_mem8_regfile #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          host_we,
  input  logic          host_re,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  input  logic          usr_we,
  input  logic [AW-1:0] usr_addr,
  input  logic [DW-1:0] usr_wdata,
  output logic [DW-1:0] usr_rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_r [DEPTH];
  logic [DW-1:0] host_rdata_r;
  logic [DW-1:0] usr_rdata_r;

  // Storage array with host-priority write arbitration per entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {DW{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (host_we && (host_addr == AW'(i))) begin
          mem_r[i] <= host_wdata;
        end else if (usr_we && (usr_addr == AW'(i))) begin
          mem_r[i] <= usr_wdata;
        end
      end
    end
  end

  // Read registers: host data only moves on an accepted read, fabric data every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_rdata_r <= {DW{1'b0}};
      usr_rdata_r  <= {DW{1'b0}};
    end else begin
      if (host_re) host_rdata_r <= mem_r[host_addr];
      usr_rdata_r <= mem_r[usr_addr];
    end
  end

  assign host_rdata = host_rdata_r;
  assign usr_rdata  = usr_rdata_r;

endmodule

// File: rtl/xb_mem8_responder.sv
// User-side responder for the Xillybus seekable 8-bit mem stream: session FSM, shared pointer, flags.
// Define XB_MEM8_EOF_EN to report end-of-file after a read of the last entry.
module xb_mem8_responder
  import xb_mem8_pkg::*;
(
  input  logic          bus_clk,
  input  logic          trn_reset_n,
  input  logic [AW-1:0] user_mem_8_addr,
  input  logic          user_mem_8_addr_update,
  input  logic          user_w_mem_8_open,
  input  logic          user_w_mem_8_wren,
  input  logic [DW-1:0] user_w_mem_8_data,
  output logic          user_w_mem_8_full,
  input  logic          user_r_mem_8_open,
  input  logic          user_r_mem_8_rden,
  output logic [DW-1:0] user_r_mem_8_data,
  output logic          user_r_mem_8_empty,
  output logic          user_r_mem_8_eof,
  input  logic [AW-1:0] usr_addr,
  input  logic          usr_we,
  input  logic [DW-1:0] usr_wdata,
  output logic [DW-1:0] usr_rdata,
  output logic          usr_host_wr,
  output logic [AW-1:0] usr_host_waddr
);

  state_e        state_r, state_s;
  logic [AW-1:0] ptr_r, ptr_s;
  logic          empty_r, empty_s;
  logic          full_r, full_s;
  logic          eof_r, eof_s;
  logic          host_wr_r;
  logic [AW-1:0] host_waddr_r;
  logic          wr_acc_s, rd_acc_s, any_open_s;

  // Next state, pointer and flags; a seek masks strobes so the core cannot see stale data.
  always_comb begin
    any_open_s = user_w_mem_8_open | user_r_mem_8_open;
    wr_acc_s   = user_w_mem_8_wren & ~full_r & ~user_mem_8_addr_update;
    rd_acc_s   = user_r_mem_8_rden & ~empty_r & ~user_mem_8_addr_update;
    state_s    = state_r;
    ptr_s      = ptr_r;
    eof_s      = 1'b0;

    case (state_r)
      IDLE, ACTIVE, SEEK: begin
        if (!any_open_s) begin
          state_s = IDLE;
        end else if (user_mem_8_addr_update) begin
          state_s = SEEK;
        end else begin
          state_s = ACTIVE;
        end
      end
      default: state_s = IDLE;
    endcase

    if (user_mem_8_addr_update) begin
      ptr_s = user_mem_8_addr;
    end else if (wr_acc_s || rd_acc_s) begin
      ptr_s = ptr_inc(ptr_r);
    end else begin
      ptr_s = ptr_r;
    end

`ifdef XB_MEM8_EOF_EN
    if (user_mem_8_addr_update || !user_r_mem_8_open) begin
      eof_s = 1'b0;
    end else if (rd_acc_s && (ptr_r == {AW{1'b1}})) begin
      eof_s = 1'b1;
    end else begin
      eof_s = eof_r;
    end
`else
    eof_s = 1'b0;
`endif

    empty_s = (state_s != ACTIVE) | ~user_r_mem_8_open | eof_s;
    full_s  = (state_s != ACTIVE) | ~user_w_mem_8_open;
  end

  // Control registers.
  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      state_r      <= IDLE;
      ptr_r        <= {AW{1'b0}};
      empty_r      <= 1'b1;
      full_r       <= 1'b1;
      eof_r        <= 1'b0;
      host_wr_r    <= 1'b0;
      host_waddr_r <= {AW{1'b0}};
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      empty_r   <= empty_s;
      full_r    <= full_s;
      eof_r     <= eof_s;
      host_wr_r <= wr_acc_s;
      if (wr_acc_s) host_waddr_r <= ptr_r;
    end
  end

  xb_mem8_regfile #(.AW(AW), .DW(DW)) u_regfile (
    .clk        (bus_clk),
    .rst_n      (trn_reset_n),
    .host_we    (wr_acc_s),
    .host_re    (rd_acc_s),
    .host_addr  (ptr_r),
    .host_wdata (user_w_mem_8_data),
    .host_rdata (user_r_mem_8_data),
    .usr_we     (usr_we),
    .usr_addr   (usr_addr),
    .usr_wdata  (usr_wdata),
    .usr_rdata  (usr_rdata)
  );

  assign user_w_mem_8_full  = full_r;
  assign user_r_mem_8_empty = empty_r;
  assign user_r_mem_8_eof   = eof_r;
  assign usr_host_wr        = host_wr_r;
  assign usr_host_waddr     = host_waddr_r;

endmodule
